// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core sharing one ALU and one req/ack memory port.
// PortIn/PortOut are memory-mapped and decoded locally, so they never start a bus cycle.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC      = 32'h0040_0000,
   parameter int          PORT_IN_WIDTH = 8,
   parameter logic [31:0] PORT_IN_ADDR  = 32'h1001_0024,
   parameter logic [31:0] PORT_OUT_ADDR = 32'h1001_0028
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [31:0]              mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic                     mem_ack,
   input  logic [31:0]              mem_rdata,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
   output logic [31:0]              PortOut,
   output logic [31:0]              ALUResultOut,
   output logic                     instr_retired,
   output logic                     halted
);
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
   state_t state, state_nx;
   logic [31:0] pc, ir, a, b, tgt, mdr, alu, simm, rs_val, rt_val, bus_addr, rf_wd;
   logic [31:0] rf [32];
   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt, rf_wa;
   logic r_type, is_jr, is_j, is_br, is_lw, is_sw, valid, port_in_hit, port_out_hit, bus_cycle, retire, rf_we;
   assign op     = ir[31:26];
   assign rs     = ir[25:21];
   assign rt     = ir[20:16];
   assign rd     = ir[15:11];
   assign shamt  = ir[10:6];
   assign funct  = ir[5:0];
   assign simm   = {{16{ir[15]}}, ir[15:0]};
   assign rs_val = rf[rs];
   assign rt_val = rf[rt];
   assign r_type = op == 6'h00;
   assign is_jr  = r_type && funct == 6'h08;
   assign is_j   = op == 6'h02 || op == 6'h03;
   assign is_br  = op == 6'h04 || op == 6'h05;
   assign is_lw  = op == 6'h23;
   assign is_sw  = op == 6'h2B;
   assign valid  = r_type ? funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02, 6'h08}
                          : op inside {6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
   // In MEM the ALU result register still holds the effective address.
   assign port_in_hit  = is_lw && (ALUResultOut & ~32'h3) == (PORT_IN_ADDR & ~32'h3);
   assign port_out_hit = is_sw && (ALUResultOut & ~32'h3) == (PORT_OUT_ADDR & ~32'h3);
   always_comb begin
      alu = a + simm;
      if (r_type)
         case (funct)
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h27:   alu = ~(a | b);
            6'h00:   alu = b << shamt;
            6'h02:   alu = b >> shamt;
            default: alu = a + b;
         endcase
      else if (op == 6'h0D)
         alu = a | {16'h0, ir[15:0]};
      else if (op == 6'h0F)
         alu = {ir[15:0], 16'h0};
      else if (is_br)
         alu = a - b;
   end
   always_comb begin
      state_nx = state;
      retire   = 1'b0;
      case (state)
         FETCH:     state_nx = mem_ack ? DECODE : FETCH;
         DECODE: begin
            state_nx = !valid ? HALT : (is_j || is_jr) ? FETCH : EXECUTE;
            retire   = valid && (is_j || is_jr);
         end
         EXECUTE: begin
            state_nx = is_br ? FETCH : (is_lw || is_sw) ? MEM : WRITEBACK;
            retire   = is_br;
         end
         MEM: begin
            state_nx = port_in_hit ? WRITEBACK : port_out_hit ? FETCH : !mem_ack ? MEM : is_sw ? FETCH : WRITEBACK;
            retire   = port_out_hit || (!port_in_hit && mem_ack && is_sw);
         end
         WRITEBACK: begin
            state_nx = FETCH;
            retire   = 1'b1;
         end
         default:   state_nx = HALT;
      endcase
   end
   // Bus outputs are gated by reset so an in-flight request drops asynchronously.
   assign bus_cycle = state == FETCH || (state == MEM && !port_in_hit && !port_out_hit);
   assign bus_addr  = state == FETCH ? pc : ALUResultOut;
   assign mem_req   = reset && bus_cycle;
   assign mem_we    = mem_req && state == MEM && is_sw;
   assign mem_addr  = mem_req ? bus_addr & ~32'h3 : '0;
   assign mem_wdata = mem_we ? b : '0;
   assign halted    = state == HALT;
   assign rf_we = state == WRITEBACK || (state == DECODE && op == 6'h03);
   assign rf_wa = state == DECODE ? 5'd31 : r_type ? rd : rt;
   assign rf_wd = state == DECODE ? pc : is_lw ? mdr : ALUResultOut;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         ir            <= '0;
         a             <= '0;
         b             <= '0;
         tgt           <= '0;
         mdr           <= '0;
         PortOut       <= '0;
         ALUResultOut  <= '0;
         instr_retired <= 1'b0;
      end else begin
         state         <= state_nx;
         instr_retired <= retire;
         case (state)
            FETCH:
               if (mem_ack) begin
                  ir <= mem_rdata;
                  pc <= pc + 32'd4;
               end
            DECODE: begin
               a   <= rs_val;
               b   <= rt_val;
               tgt <= pc + (simm << 2);
               if (is_j)
                  pc <= {pc[31:28], ir[25:0], 2'b00};
               else if (is_jr)
                  pc <= rs_val;
            end
            EXECUTE: begin
               ALUResultOut <= alu;
               if (is_br && ((op == 6'h04) == (a == b)))
                  pc <= tgt;
            end
            MEM: begin
               if (port_in_hit)
                  mdr <= 32'(PortIn);
               else if (mem_ack)
                  mdr <= mem_rdata;
               if (port_out_hit)
                  PortOut <= b;
            end
            default: ;
         endcase
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int i = 0; i < 32; i++)
            rf[i] <= '0;
      end else if (rf_we && rf_wa != 5'd0)
         rf[rf_wa] <= rf_wd;
endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Multicycle successor to the single-cycle MIPS processor. It executes the same instruction subset plus lw/sw, lui, sll/srl and jump/link, using one shared ALU and a single external memory port. The memory port uses a req/ack handshake, so program/data storage may insert any number of wait states. Memory-mapped PortIn/PortOut is decoded inside the core, so the top level only attaches one memory.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
PORT_IN_WIDTH, 8, width of PortIn; zero-extended to 32 bits on read.
PORT_IN_ADDR, 32'h1001_0024, lw from this address returns PortIn; no bus cycle.
PORT_OUT_ADDR, 32'h1001_0028, sw to this address updates PortOut; no bus cycle.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
mem_req  out  1  bus request; held high until mem_ack.
mem_we  out  1  1=write, 0=read; valid while mem_req.
mem_addr  out  32  byte address (word aligned); valid while mem_req.
mem_wdata  out  32  store data; valid while mem_req and mem_we.
mem_ack  in  1  transfer done this cycle; mem_rdata valid when read.
mem_rdata  in  32  read data.
PortIn  in  PORT_IN_WIDTH  input port.
PortOut  out  32  output port register.
ALUResultOut  out  32  registered ALU result of the last EXECUTE.
instr_retired  out  1  one-cycle pulse when an instruction completes.
halted  out  1  high once an unsupported opcode/funct has been decoded.

Behaviour:
Reset (reset=0, async):
- PC=RESET_PC; state=FETCH.
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
- PortOut=0, ALUResultOut=0, instr_retired=0, halted=0.
- All 32 registers = 0.
- An in-flight bus cycle is abandoned; mem_req drops immediately.

Registers:
- $0 always reads 0; writes to $0 are discarded.
- RegFile writes occur on the clock edge that leaves WRITEBACK, or on the DECODE edge for jal.

FSM states: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On the edge where mem_ack=1: IR<=mem_rdata, PC<=PC+4, go to DECODE. Zero-wait memory (ack in the first req cycle) is legal.
- DECODE: read rs/rt; compute branch target = PC + (sext(imm)<<2).
  - j: PC<={PC[31:28], target, 2'b00}.
  - jal: same PC update, and $31<=PC (i.e. old PC+4).
  - jr (op 0, funct 0x08): PC<=rs.
  - j/jal/jr retire here and go to FETCH.
  - Unsupported op/funct: go to HALT.
  - Otherwise go to EXECUTE.
- EXECUTE: ALU computes; ALUResultOut<=result.
  - beq/bne: compare rs and rt; if taken, PC<=target. Retire and go to FETCH.
  - lw/sw: address = rs + sext(imm); go to MEM.
  - All others: go to WRITEBACK.
- MEM:
  - Address == PORT_IN_ADDR (lw): data={0, PortIn}; one cycle; go to WRITEBACK.
  - Address == PORT_OUT_ADDR (sw): PortOut<=rt; one cycle; retire; go to FETCH.
  - Otherwise: mem_req=1 with mem_we = (op==sw). Hold until ack. sw retires on ack and goes to FETCH; lw latches mem_rdata and goes to WRITEBACK.
- WRITEBACK: write rd (R-type) or rt (I-type); retire; go to FETCH.
- HALT: terminal until reset. halted=1, mem_req=0, PC frozen.

Supported R-type funct codes: add 0x20, sub 0x22, and 0x24, or 0x25, nor 0x27, sll 0x00, srl 0x02 (both use shamt), jr 0x08.

Supported opcodes: addi 0x08, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.

Arithmetic and extension:
- 32-bit, wrap-around; no overflow trap.
- ori zero-extends imm.
- addi, lw, sw and branches sign-extend imm.
- lui: rt={imm,16'h0}.

Latency with n-cycle fetch and m-cycle data access (n,m ≥ 1):
- R/I ALU ops: n+3 cycles.
- Branches: n+2.
- j/jal/jr: n+1.
- lw: n+m+3.
- sw: n+m+2.
- Port lw: n+4.
- Port sw: n+3.

Bus rules:
- Address is always word aligned; the low 2 bits are ignored.
- mem_ack while mem_req=0 is ignored.
- instr_retired pulses exactly once per completed instruction.

Test Plan:
- Zero-wait memory; program "addi $t0,$0,5; addi $t1,$0,-3; add $t2,$t0,$t1" -> $t2=2; ALUResultOut=2; three instr_retired pulses; 4 cycles per instruction.
- 3-wait-state memory on every access; "sw $t0,0($sp); lw $t1,0($sp)" -> mem_req held constant until ack; $t1=$t0; mem_we=1 only on the store cycle.
- PortIn=8'hA5; "lw $t0,PORT_IN; sll $t1,$t0,4; sw $t1,PORT_OUT" -> PortOut=32'h0000_0A50; no mem_req during either data access.
- Branch/jump: bne with equal operands not taken (PC=+4); beq with imm=-2 taken (PC=branch PC-4); jal then jr $ra returns to jal PC+4 with $31 correct.
- Opcode 0x3F fetched -> halted=1 after DECODE; mem_req stays 0 for 20 cycles; reset low then high -> fetch restarts at RESET_PC.
- Assert reset during FETCH wait state -> mem_req drops in the same cycle (async); all registers 0; PortOut=0.
